// File: rtl/btb_2way_predictor.sv
// btb_2way_predictor: 2-way set-associative BTB with 2-bit direction counters and per-set LRU victim choice.
module btb_2way_predictor #(
    parameter int NUM_SETS = 32,
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] pred_next_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target
);
    logic [NUM_SETS-1:0] valid_q [2];
    logic [TAG_W-1:0]    tag_q    [2][NUM_SETS];
    logic [31:0]         target_q [2][NUM_SETS];
    logic [1:0]          ctr_q    [2][NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic [1:0]       l_hit, u_hit;
    logic             l_way, u_way, victim;
    logic [1:0]       u_ctr, u_ctr_nxt;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];

    assign l_hit[0] = valid_q[0][l_idx] && tag_q[0][l_idx] == l_tag;
    assign l_hit[1] = valid_q[1][l_idx] && tag_q[1][l_idx] == l_tag;
    assign u_hit[0] = valid_q[0][u_idx] && tag_q[0][u_idx] == u_tag;
    assign u_hit[1] = valid_q[1][u_idx] && tag_q[1][u_idx] == u_tag;

    // way 0 takes precedence should both ways ever match
    assign l_way = !l_hit[0];
    assign u_way = !u_hit[0];

    assign pred_hit     = |l_hit;
    assign pred_taken   = pred_hit && ctr_q[l_way][l_idx][1];
    assign pred_target  = pred_hit ? target_q[l_way][l_idx] : 32'd0;
    assign pred_next_pc = pred_taken ? pred_target : lookup_pc + 32'd4;

    assign victim    = !valid_q[0][u_idx] ? 1'b0 : !valid_q[1][u_idx] ? 1'b1 : lru_q[u_idx];
    assign u_ctr     = ctr_q[u_way][u_idx];
    assign u_ctr_nxt = update_taken ? (u_ctr == 2'd3 ? 2'd3 : u_ctr + 2'd1)
                                    : (u_ctr == 2'd0 ? 2'd0 : u_ctr - 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                ctr_q[0][s] <= 2'b01;
                ctr_q[1][s] <= 2'b01;
            end
        end else if (update_valid) begin
            if (|u_hit) begin
                ctr_q[u_way][u_idx] <= u_ctr_nxt;
                if (update_taken)
                    target_q[u_way][u_idx] <= update_target;
                lru_q[u_idx] <= ~u_way;
            end else if (update_taken) begin
                valid_q[victim][u_idx]  <= 1'b1;
                tag_q[victim][u_idx]    <= u_tag;
                target_q[victim][u_idx] <= update_target;
                ctr_q[victim][u_idx]    <= 2'b10;
                lru_q[u_idx]            <= ~victim;
            end
        end
    end
endmodule

// File: tb/tb_btb_2way_predictor.sv
// tb_btb_2way_predictor: scoreboard bench over three BTB sizes (32, 2 and 256 sets).
module tb_btb_2way_predictor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] lpc [3];
    logic [31:0] upc [3];
    logic [31:0] utg [3];
    logic        uv  [3];
    logic        ut  [3];
    logic        hit [3];
    logic        tkn [3];
    logic [31:0] tgt [3];
    logic [31:0] npc [3];

    typedef struct {
        string       tag;
        int          d;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
    } exp_t;
    exp_t q [$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btb_2way_predictor #(.NUM_SETS(32)) dut0 (
        .clk(clk), .reset(reset), .lookup_pc(lpc[0]), .pred_hit(hit[0]), .pred_taken(tkn[0]),
        .pred_target(tgt[0]), .pred_next_pc(npc[0]), .update_valid(uv[0]), .update_pc(upc[0]),
        .update_taken(ut[0]), .update_target(utg[0]));
    btb_2way_predictor #(.NUM_SETS(2)) dut1 (
        .clk(clk), .reset(reset), .lookup_pc(lpc[1]), .pred_hit(hit[1]), .pred_taken(tkn[1]),
        .pred_target(tgt[1]), .pred_next_pc(npc[1]), .update_valid(uv[1]), .update_pc(upc[1]),
        .update_taken(ut[1]), .update_target(utg[1]));
    btb_2way_predictor #(.NUM_SETS(256)) dut2 (
        .clk(clk), .reset(reset), .lookup_pc(lpc[2]), .pred_hit(hit[2]), .pred_taken(tkn[2]),
        .pred_target(tgt[2]), .pred_next_pc(npc[2]), .update_valid(uv[2]), .update_pc(upc[2]),
        .update_taken(ut[2]), .update_target(utg[2]));

    function automatic int num_sets(input int d);
        return d == 0 ? 32 : d == 1 ? 2 : 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".hit"},    {31'd0, hit[e.d]}, {31'd0, e.hit});
            check({e.tag, ".taken"},  {31'd0, tkn[e.d]}, {31'd0, e.taken});
            check({e.tag, ".target"}, tgt[e.d], e.target);
            check({e.tag, ".next_pc"}, npc[e.d], e.next_pc);
        end
    end

    task automatic look(input string tag, input int d, input logic [31:0] pc,
                        input logic h, input logic t, input logic [31:0] target);
        exp_t e;
        lpc[d] = pc;
        e.tag = $sformatf("%s/ns%0d", tag, num_sets(d));
        e.d = d;
        e.hit = h;
        e.taken = t;
        e.target = target;
        e.next_pc = t ? target : pc + 32'd4;
        q.push_back(e);
    endtask

    task automatic train(input int d, input logic [31:0] pc, input logic t, input logic [31:0] target);
        uv[d] = 1'b1;
        upc[d] = pc;
        ut[d] = t;
        utg[d] = target;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) uv[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic alloc_test(input int d);
        logic [31:0] a, b, c, x;
        a = 32'h100;
        b = a + 32'(4 * num_sets(d));
        c = a + 32'(8 * num_sets(d));
        x = a + 32'(12 * num_sets(d));
        do_reset();
        train(d, a, 1'b1, 32'h1000); step();
        train(d, b, 1'b1, 32'h2000); step();
        look("alloc_b", d, b, 1'b1, 1'b1, 32'h2000);
        train(d, a, 1'b1, 32'h1000); step();
        train(d, c, 1'b1, 32'h3000); step();
        look("keep_a", d, a, 1'b1, 1'b1, 32'h1000); step();
        look("new_c", d, c, 1'b1, 1'b1, 32'h3000); step();
        look("evict_b", d, b, 1'b0, 1'b0, 32'h0); step();
        train(d, x, 1'b0, 32'h4000); step();
        look("nt_miss_a", d, a, 1'b1, 1'b1, 32'h1000); step();
        look("nt_miss_c", d, c, 1'b1, 1'b1, 32'h3000); step();
        look("nt_miss_d", d, x, 1'b0, 1'b0, 32'h0); step();
        train(d, x, 1'b1, 32'h4000); step();
        look("lru_evict_a", d, a, 1'b0, 1'b0, 32'h0); step();
        look("lru_keep_c", d, c, 1'b1, 1'b1, 32'h3000); step();
        look("lru_new_d", d, x, 1'b1, 1'b1, 32'h4000); step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            lpc[i] = 32'h0; upc[i] = 32'h0; utg[i] = 32'h0; uv[i] = 1'b0; ut[i] = 1'b0;
        end
        @(posedge clk); #1;
        do_reset();
        look("reset", 0, 32'h100, 1'b0, 1'b0, 32'h0); step();
        train(0, 32'h100, 1'b1, 32'h200);
        look("read_old", 0, 32'h100, 1'b0, 1'b0, 32'h0); step();
        look("first_hit", 0, 32'h100, 1'b1, 1'b1, 32'h200); step();
        look("alias", 0, 32'h180, 1'b0, 1'b0, 32'h0); step();
        train(0, 32'h100, 1'b0, 32'h999); step();
        look("ctr1", 0, 32'h100, 1'b1, 1'b0, 32'h200); step();
        train(0, 32'h100, 1'b0, 32'h999); step();
        look("ctr0", 0, 32'h100, 1'b1, 1'b0, 32'h200); step();
        train(0, 32'h100, 1'b0, 32'h999); step();
        train(0, 32'h100, 1'b1, 32'h200); step();
        look("sat_low", 0, 32'h100, 1'b1, 1'b0, 32'h200); step();
        train(0, 32'h100, 1'b1, 32'h200); step();
        train(0, 32'h100, 1'b1, 32'h200); step();
        train(0, 32'h100, 1'b1, 32'h200); step();
        train(0, 32'h100, 1'b1, 32'h300); step();
        look("new_target", 0, 32'h100, 1'b1, 1'b1, 32'h300); step();
        train(0, 32'h100, 1'b0, 32'h999); step();
        look("sat_high", 0, 32'h100, 1'b1, 1'b1, 32'h300); step();
        look("wrap", 0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0); step();
        reset = 1'b1;
        train(0, 32'h400, 1'b1, 32'h500);
        step();
        reset = 1'b0;
        look("rst_clear", 0, 32'h100, 1'b0, 1'b0, 32'h0); step();
        look("rst_drop", 0, 32'h400, 1'b0, 1'b0, 32'h0); step();
        for (int d = 0; d < 3; d++) alloc_test(d);
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_2way_predictor.md
# btb_2way_predictor

Parametrised 2-way set-associative branch target buffer with per-entry 2-bit saturating direction counters and per-set LRU replacement. It sits beside the IF-stage PC register and supplies a same-cycle next-PC prediction. It is trained by the EX stage once a control-flow instruction resolves. It supersedes the direct-mapped, hit-only BTB: it adds direction prediction, associativity, victim selection and a configurable set count.

## Interface
- `NUM_SETS`, 32, number of sets; power of two, 2..256; `IDX_W = log2(NUM_SETS)`
- `TAG_W`, `30 - IDX_W`, derived, not overridable; tag is `pc[31:IDX_W+2]`
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `lookup_pc`  in  32  fetch PC
- `pred_hit`  out  1  a valid way in the indexed set matches the tag
- `pred_taken`  out  1  `pred_hit && counter[1]` of the hitting way
- `pred_target`  out  32  stored target of the hitting way; 0 on miss
- `pred_next_pc`  out  32  `pred_taken ? pred_target : lookup_pc + 4`
- `update_valid`  in  1  one-cycle training strobe from EX
- `update_pc`  in  32  PC of the resolved branch/jump
- `update_taken`  in  1  actual direction
- `update_target`  in  32  actual taken target

## Operation
- Storage per set: 2 ways × {valid, tag[TAG_W], target[32], ctr[2]}, plus 1 LRU bit (value = way to victimise next).
- Index = `pc[IDX_W+1:2]`; `pc[1:0]` ignored.
- Lookup: purely combinational from the arrays. If both ways match, which is an illegal state, way 0 wins.
- Update when `update_valid`=1, using the index/tag of `update_pc`:
  - Hit in way w:
    - ctr saturating +1 if taken, −1 if not taken (3 and 0 hold).
    - If taken, target ← `update_target`. A not-taken update leaves the target unchanged.
    - LRU ← ~w.
  - Miss, taken: allocate.
    - Victim is the first invalid way (way 0 before way 1); if both ways are valid, the victim is the LRU way.
    - Write valid=1, tag, target, ctr=2'b10 (weakly taken); LRU ← ~victim.
  - Miss, not taken: no state change, including no LRU change.
- `update_valid`=0: no state change.
- Allocation happens only on a miss, so duplicate tags within a set never arise in normal operation.

## Timing
- Lookup latency 0: outputs are valid in the same cycle as `lookup_pc`.
- Update takes effect at the rising edge where `update_valid`=1 and is visible to lookup from the next cycle.
- Same-cycle lookup and update to the same set: lookup returns pre-update contents (read-old).
- Reset (synchronous, takes priority over update):
  - All valid bits ← 0, all LRU ← 0, all ctr ← 2'b01. Tags and targets need not be reset.
  - From the cycle after the reset edge: `pred_hit`=0, `pred_taken`=0, `pred_target`=0, `pred_next_pc`=`lookup_pc`+4.
- Reset asserted mid-stream discards any simultaneous update. Training resumes on the first `update_valid` after reset deasserts.
- Arithmetic:
  - `lookup_pc + 4` is 32-bit modulo and wraps at 0xFFFFFFFC → 0.
  - Counter arithmetic never wraps.

## Test plan
- Reset, then lookup 0x0000_0100 → hit=0, taken=0, target=0, next_pc=0x104.
- Update pc=0x100, taken, target=0x200; next cycle lookup 0x100 → hit=1, taken=1, next_pc=0x200. Lookup of aliasing pc 0x100+4·NUM_SETS → hit=0.
- Same pc: 2 not-taken updates → ctr 2→1→0, taken=0, next_pc=0x104, target still 0x200. 4 taken updates → ctr saturates at 3. One not-taken → ctr 2, taken=1.
- NUM_SETS=32: allocate A=0x100, B=0x180, then lookup-train A again (hit update, LRU→B's way). Allocate C=0x200 → B evicted; A and C hit, B misses. Not-taken update of unknown D=0x280 → no eviction, A/C still hit.
- Same-cycle lookup and first taken update of 0x100 → lookup shows hit=0 that cycle and hit=1 the next. Reset with `update_valid`=1 in the same cycle → entry not written, hit=0 after.
- Wrap: lookup 0xFFFF_FFFC on miss → next_pc=0x0000_0000. Repeat the allocation test with NUM_SETS=2 and NUM_SETS=256.
